axi_burst_sequencer: RTL
========================

# axi_burst_sequencer

Burst controller that shares the AXI-style burst datapath between one write requester and one read requester. It arbitrates round-robin, latches the winner's burst attributes, and generates the per-beat address (FIXED/INCR/WRAP). It drives the beat strobe and last-beat flag to the datapath, and reports completion back to the requester. It sits between the testbench/master request sources and the datapath's `transfer/bsize/blen/btyp/dlast/wadd/radd` pins.

## Interface
- `size`, 4, bytes per data word; address width is `size*8` bits.
- `aclk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-high (asserted = 1), despite the suffix.
- `wr_req`  in  1  write burst request; held until `wr_gnt`.
- `wr_addr`  in  size*8  write start address.
- `wr_blen`  in  6  write beats minus 1 (1..64 beats).
- `wr_bsize`  in  9  write bytes per beat; power of two, 1..size.
- `wr_btyp`  in  2  write burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `wr_gnt`  out  1  one-cycle pulse; write attributes captured.
- `wr_done`  out  1  one-cycle pulse; write burst complete.
- `rd_req`, `rd_addr`, `rd_blen`, `rd_bsize`, `rd_btyp`, `rd_gnt`, `rd_done`: read-side equivalents, same widths and rules.
- `beat_rdy`  in  1  datapath accepts the current beat.
- `transfer`  out  1  current beat valid.
- `bsize`, `blen`, `btyp`  out  9/6/2  latched attributes of the active burst.
- `dlast`  out  1  current beat is the final beat.
- `wadd`  out  size*8  beat address; valid during a write burst, 0 otherwise.
- `radd`  out  size*8  beat address; valid during a read burst, 0 otherwise.

## Operation
- States: IDLE, WBURST, RBURST, DONE.
- IDLE:
  - Only `wr_req` high -> WBURST.
  - Only `rd_req` high -> RBURST.
  - Both high -> grant the side not served last. The last-served pointer resets to "read", so write wins the first tie.
  - On grant, pulse `*_gnt` and latch addr/blen/bsize/btyp. The beat counter is set to 0.
- WBURST/RBURST:
  - `transfer`=1.
  - A beat completes when `transfer && beat_rdy`. The counter then increments and the address advances.
  - `dlast`=1 while counter == latched `blen`.
  - The last beat completing moves to DONE.
  - Requests seen during a burst are ignored; they are arbitrated on the next IDLE.
- DONE: pulse `*_done` for the side just served, update the last-served pointer, then go to IDLE.
- Address update per completed beat:
  - FIXED: unchanged.
  - INCR: addr + bsize, modulo 2^(size*8).
  - WRAP: boundary B = bsize*(blen+1). New addr = (addr & ~(B-1)) | ((addr+bsize) & (B-1)). Legal only for blen ∈ {1,3,7,15}.
- Illegal WRAP length and btyp 11 are executed as INCR. `btyp` output still shows the requested value.
- A requester dropping `*_req` before grant has no effect. Attributes are don't-care after grant.

## Timing
- Reset values:
  - State IDLE.
  - `transfer`, `dlast`, `wr_gnt`, `rd_gnt`, `wr_done`, `rd_done` = 0.
  - `bsize`, `blen`, `btyp`, `wadd`, `radd` = 0.
  - Last-served = read.
- Request high in IDLE at edge k:
  - `*_gnt` is high during cycle k..k+1.
  - `transfer` and the first-beat address are valid from the same edge (grant and first beat coincide).
- Beats are accepted back-to-back when `beat_rdy` stays high. With `beat_rdy` low, the beat, address and `dlast` hold.
- `*_done` is high in the cycle after the last beat's acceptance edge. IDLE follows. The earliest next grant is one cycle later.
- Minimum occupancy is beats + 2 cycles.
- `resetn` asserted mid-burst: all outputs take reset values at that edge. The burst is abandoned and no `*_done` is issued.

## Configuration
- `AXI_BURST_SEQ_WRAP_EN` defined: WRAP address generation as above.
- `AXI_BURST_SEQ_WRAP_EN` undefined: the wrap logic is omitted. btyp 10 is executed as INCR; all other behaviour is identical.

## Test plan
- Write INCR, addr 0x100, bsize 4, blen 3, `beat_rdy`=1 -> `wadd` 0x100, 0x104, 0x108, 0x10C. `dlast` on beat 4. `wr_done` one cycle later.
- Read WRAP, addr 0x0C, bsize 4, blen 3 (B=16) -> `radd` 0x0C, 0x00, 0x04, 0x08. Without the macro: 0x0C, 0x10, 0x14, 0x18.
- `wr_req` and `rd_req` high continuously, blen 0 each -> grants alternate W, R, W, R, each burst 3 cycles.
- FIXED, addr 0x40, blen 2, `beat_rdy` toggling 1-0-1-0-1 -> `wadd` stays 0x40; `transfer` stays high 5 cycles; `dlast` only during the third beat.
- INCR, addr 0xFFFFFFFC, bsize 4, blen 1 -> addresses 0xFFFFFFFC, 0x00000000.
- `resetn` asserted during beat 2 of 4 -> the next cycle has `transfer`=0, `wadd`=0, no `wr_done`; a new `rd_req` is granted on the first cycle after release.

Source files
------------

// File: rtl/axi_burst_sequencer.sv
// axi_burst_sequencer: round-robin write/read burst sequencer with FIXED/INCR/WRAP beat addressing; WRAP generation needs AXI_BURST_SEQ_WRAP_EN, otherwise WRAP runs as INCR
module axi_burst_sequencer #(
    parameter int size = 4
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic [size*8-1:0] wr_addr,
    input  logic [5:0]        wr_blen,
    input  logic [8:0]        wr_bsize,
    input  logic [1:0]        wr_btyp,
    output logic              wr_gnt,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [size*8-1:0] rd_addr,
    input  logic [5:0]        rd_blen,
    input  logic [8:0]        rd_bsize,
    input  logic [1:0]        rd_btyp,
    output logic              rd_gnt,
    output logic              rd_done,
    input  logic              beat_rdy,
    output logic              transfer,
    output logic [8:0]        bsize,
    output logic [5:0]        blen,
    output logic [1:0]        btyp,
    output logic              dlast,
    output logic [size*8-1:0] wadd,
    output logic [size*8-1:0] radd
);
    localparam int AW = size * 8;
    typedef enum logic [1:0] {IDLE, WBURST, RBURST, DONE} state_t;
    state_t        state_q;
    logic [AW-1:0] addr_q, addr_d, addr_inc;
    logic [5:0]    cnt_q, blen_q;
    logic [8:0]    bsize_q;
    logic [1:0]    btyp_q;
    logic          transfer_q, dlast_q, wr_gnt_q, rd_gnt_q, wr_done_q, rd_done_q;
    logic          wr_side_q, last_rd_q, pick_wr, pick_rd;
`ifdef AXI_BURST_SEQ_WRAP_EN
    logic          wrap_ok;
    logic [AW-1:0] wrap_mask;
`endif

    assign pick_wr  = wr_req && (!rd_req || last_rd_q);
    assign pick_rd  = rd_req && !pick_wr;
    assign wr_gnt   = wr_gnt_q;
    assign rd_gnt   = rd_gnt_q;
    assign wr_done  = wr_done_q;
    assign rd_done  = rd_done_q;
    assign transfer = transfer_q;
    assign dlast    = dlast_q;
    assign bsize    = bsize_q;
    assign blen     = blen_q;
    assign btyp     = btyp_q;
    assign wadd     = state_q == WBURST ? addr_q : '0;
    assign radd     = state_q == RBURST ? addr_q : '0;

    // Next beat address; anything other than FIXED or a legal WRAP advances as INCR
    always_comb begin
        addr_inc = addr_q + AW'(bsize_q);
`ifdef AXI_BURST_SEQ_WRAP_EN
        wrap_ok   = btyp_q == 2'b10 && (blen_q == 6'd1 || blen_q == 6'd3 || blen_q == 6'd7 || blen_q == 6'd15);
        wrap_mask = AW'(bsize_q) * (AW'(blen_q) + AW'(1)) - AW'(1);
        addr_d    = btyp_q == 2'b00 ? addr_q : wrap_ok ? (addr_q & ~wrap_mask) | (addr_inc & wrap_mask) : addr_inc;
`else
        addr_d = btyp_q == 2'b00 ? addr_q : addr_inc;
`endif
    end

    // Arbitrate in IDLE, step beats while the datapath accepts, pulse done, then return to IDLE
    always_ff @(posedge aclk) begin
        if (resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            blen_q     <= '0;
            bsize_q    <= '0;
            btyp_q     <= '0;
            transfer_q <= 1'b0;
            dlast_q    <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_side_q  <= 1'b0;
            last_rd_q  <= 1'b1;
        end else begin
            wr_gnt_q  <= 1'b0;
            rd_gnt_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            case (state_q)
                IDLE: if (pick_wr || pick_rd) begin
                    state_q    <= pick_wr ? WBURST : RBURST;
                    wr_side_q  <= pick_wr;
                    wr_gnt_q   <= pick_wr;
                    rd_gnt_q   <= pick_rd;
                    transfer_q <= 1'b1;
                    cnt_q      <= '0;
                    addr_q     <= pick_wr ? wr_addr : rd_addr;
                    blen_q     <= pick_wr ? wr_blen : rd_blen;
                    bsize_q    <= pick_wr ? wr_bsize : rd_bsize;
                    btyp_q     <= pick_wr ? wr_btyp : rd_btyp;
                    dlast_q    <= (pick_wr ? wr_blen : rd_blen) == 6'd0;
                end
                WBURST, RBURST: if (beat_rdy) begin
                    if (dlast_q) begin
                        state_q    <= DONE;
                        transfer_q <= 1'b0;
                        dlast_q    <= 1'b0;
                        wr_done_q  <= wr_side_q;
                        rd_done_q  <= !wr_side_q;
                    end else begin
                        cnt_q   <= cnt_q + 6'd1;
                        addr_q  <= addr_d;
                        dlast_q <= cnt_q + 6'd1 == blen_q;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    last_rd_q <= !wr_side_q;
                end
            endcase
        end
    end
endmodule
